// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path.
// States, opcodes, ALUOp and PCSource codes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_ADDR    = 4'd3,
    S_MEM_RD  = 4'd4,
    S_LW_WB   = 4'd5,
    S_MEM_WR  = 4'd6,
    S_R_EX    = 4'd7,
    S_R_WB    = 4'd8,
    S_BEQ     = 4'd9,
    S_JMP     = 4'd10,
    S_ADDI_EX = 4'd11,
    S_ADDI_WB = 4'd12,
    S_HALT    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  function automatic logic is_wait(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the main FSM and the datapath.
// master = controller, slave = datapath / memory side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic       RegDst;
  logic       halted;
  logic       illegal_op;
  logic       bus_err;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD,
    output MemRead, MemWrite, IRWrite,
    output MemtoReg, PCSource, ALUOp,
    output ALUSrcA, ALUSrcB, RegWrite,
    output RegDst, halted, illegal_op,
    output bus_err
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD,
    input  MemRead, MemWrite, IRWrite,
    input  MemtoReg, PCSource, ALUOp,
    input  ALUSrcA, ALUSrcB, RegWrite,
    input  RegDst, halted, illegal_op,
    input  bus_err
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle datapath.
// Sequences instructions, waits on memory with timeout, halts on faults.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input logic clk,
  input logic rst_n,
  multicycle_control_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ill_q, berr_q;
  logic             set_ill, set_berr;

  logic       pc_wr, pc_wr_cond, iord;
  logic       mem_rd, mem_wr, ir_wr;
  logic       mem2reg, alu_src_a;
  logic [1:0] pc_src, alu_op, alu_src_b;
  logic       reg_wr, reg_dst, halt;

  // state, wait counter and sticky fault flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_RST;
      cnt    <= '0;
      ill_q  <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ill_q  <= ill_q | set_ill;
      berr_q <= berr_q | set_berr;
    end
  end

  // next state and Moore decode (FETCH loads IR/PC on ready)
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = '0;
    set_ill    = 1'b0;
    set_berr   = 1'b0;
    pc_wr      = 1'b0;
    pc_wr_cond = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    mem2reg    = 1'b0;
    alu_src_a  = 1'b0;
    pc_src     = PC_ALU;
    alu_op     = ALU_ADD;
    alu_src_b  = SRCB_B;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    halt       = 1'b0;

    case (state)
      S_RST: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRCB_4;
        alu_op    = ALU_ADD;
        pc_src    = PC_ALU;
        if (bus.mem_ready) begin
          ir_wr     = 1'b1;
          pc_wr     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM2;
        alu_op    = ALU_ADD;
        unique case (1'b1)
          (bus.opcode == OP_RTYPE):
            state_nxt = S_R_EX;
          (bus.opcode == OP_LW),
          (bus.opcode == OP_SW):
            state_nxt = S_ADDR;
          (bus.opcode == OP_BEQ):
            state_nxt = S_BEQ;
          (bus.opcode == OP_J):
            state_nxt = S_JMP;
          (bus.opcode == OP_ADDI):
            state_nxt = S_ADDI_EX;
          default: begin
            state_nxt = S_HALT;
            set_ill   = 1'b1;
          end
        endcase
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        if (bus.opcode == OP_LW)
          state_nxt = S_MEM_RD;
        else if (bus.opcode == OP_SW)
          state_nxt = S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (bus.mem_ready) state_nxt = S_LW_WB;
      end
      S_LW_WB: begin
        reg_wr    = 1'b1;
        mem2reg   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEM_WR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        if (bus.mem_ready) state_nxt = S_FETCH;
      end
      S_R_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_B;
        alu_op    = ALU_FUNCT;
        state_nxt = S_R_WB;
      end
      S_R_WB: begin
        reg_wr    = 1'b1;
        reg_dst   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_SUB;
        pc_wr_cond = 1'b1;
        pc_src     = PC_ALUOUT;
        state_nxt  = S_FETCH;
      end
      S_JMP: begin
        pc_wr     = 1'b1;
        pc_src    = PC_JUMP;
        state_nxt = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        state_nxt = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_wr    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: halt = 1'b1;
      default: state_nxt = S_HALT;
    endcase

    // a stalled wait state counts up and gives up at the last slot
    if (is_wait(state) && !bus.mem_ready) begin
      if (cnt == CNT_LAST) begin
        state_nxt = S_HALT;
        set_berr  = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  assign bus.PCWrite     = pc_wr;
  assign bus.PCWriteCond = pc_wr_cond;
  assign bus.IorD        = iord;
  assign bus.MemRead     = mem_rd;
  assign bus.MemWrite    = mem_wr;
  assign bus.IRWrite     = ir_wr;
  assign bus.MemtoReg    = mem2reg;
  assign bus.PCSource    = pc_src;
  assign bus.ALUOp       = alu_op;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.RegWrite    = reg_wr;
  assign bus.RegDst      = reg_dst;
  assign bus.halted      = halt;
  assign bus.illegal_op  = ill_q;
  assign bus.bus_err     = berr_q;

endmodule
